// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; predicts at fetch, trains and redirects from execute.
module branch_predictor #(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = $clog2(ENTRIES),
    parameter int STAT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          fetchPC,
    output logic                 predTaken,
    output logic [31:0]          predTarget,
    input  logic                 resolveValid,
    input  logic [31:0]          resolvePC,
    input  logic                 resolveTaken,
    input  logic [31:0]          resolveTarget,
    input  logic                 resolvePredTaken,
    input  logic [31:0]          resolvePredTarget,
    output logic                 mispredict,
    output logic [31:0]          redirectPC,
    output logic [STAT_BITS-1:0] branchCount,
    output logic [STAT_BITS-1:0] mispredictCount
);
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          ctr_d    [ENTRIES];
    logic [STAT_BITS-1:0] branch_count_q, branch_count_d, mis_count_q, mis_count_d;
    logic [INDEX_BITS-1:0] f_idx, r_idx;
    logic [TAG_BITS-1:0]   f_tag, r_tag;
    logic                  f_hit, r_hit;
    logic [1:0]            r_ctr;

    always_comb begin
        f_idx = fetchPC[INDEX_BITS+1:2];
        f_tag = fetchPC[31:INDEX_BITS+2];
        r_idx = resolvePC[INDEX_BITS+1:2];
        r_tag = resolvePC[31:INDEX_BITS+2];
        f_hit = valid_q[f_idx] && tag_q[f_idx] == f_tag;
        r_hit = valid_q[r_idx] && tag_q[r_idx] == r_tag;
        r_ctr = ctr_q[r_idx];
        predTaken  = !rst && f_hit && ctr_q[f_idx][1];
        predTarget = predTaken ? target_q[f_idx] : fetchPC + 32'd4;
        mispredict = resolveValid && (resolvePredTaken != resolveTaken ||
                     (resolveTaken && resolvePredTarget != resolveTarget));
        redirectPC = (resolveValid && resolveTaken) ? resolveTarget : resolvePC + 32'd4;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        // A not-taken miss leaves the table alone; anything else trains or allocates.
        if (resolveValid && (r_hit || resolveTaken)) begin
            valid_d[r_idx]  = 1'b1;
            tag_d[r_idx]    = r_tag;
            target_d[r_idx] = resolveTaken ? resolveTarget : target_q[r_idx];
            ctr_d[r_idx]    = !r_hit ? 2'b10 :
                              resolveTaken ? (r_ctr == 2'b11 ? 2'b11 : r_ctr + 2'd1) :
                              (r_ctr == 2'b00 ? 2'b00 : r_ctr - 2'd1);
        end
        branch_count_d = branch_count_q + STAT_BITS'(resolveValid && !(&branch_count_q));
        mis_count_d    = mis_count_q + STAT_BITS'(mispredict && !(&mis_count_q));
        branchCount     = branch_count_q;
        mispredictCount = mis_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '{default: 1'b0};
            tag_q          <= '{default: '0};
            target_q       <= '{default: 32'd0};
            ctr_q          <= '{default: 2'b01};
            branch_count_q <= '0;
            mis_count_q    <= '0;
        end else begin
            valid_q        <= valid_d;
            tag_q          <= tag_d;
            target_q       <= target_d;
            ctr_q          <= ctr_d;
            branch_count_q <= branch_count_d;
            mis_count_q    <= mis_count_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of prediction, training, redirect and statistics saturation.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetchPC;
    logic        resolveValid, resolveTaken, resolvePredTaken;
    logic [31:0] resolvePC, resolveTarget, resolvePredTarget;
    logic        predTaken, mispredict, s_predTaken, s_mispredict;
    logic [31:0] predTarget, redirectPC, s_predTarget, s_redirectPC;
    logic [15:0] branchCount, mispredictCount;
    logic [3:0]  s_branchCount, s_mispredictCount;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst(rst), .fetchPC(fetchPC), .predTaken(predTaken), .predTarget(predTarget),
        .resolveValid(resolveValid), .resolvePC(resolvePC), .resolveTaken(resolveTaken),
        .resolveTarget(resolveTarget), .resolvePredTaken(resolvePredTaken),
        .resolvePredTarget(resolvePredTarget), .mispredict(mispredict), .redirectPC(redirectPC),
        .branchCount(branchCount), .mispredictCount(mispredictCount)
    );

    branch_predictor #(.STAT_BITS(4)) dut_s (
        .clk(clk), .rst(rst), .fetchPC(fetchPC), .predTaken(s_predTaken), .predTarget(s_predTarget),
        .resolveValid(resolveValid), .resolvePC(resolvePC), .resolveTaken(resolveTaken),
        .resolveTarget(resolveTarget), .resolvePredTaken(resolvePredTaken),
        .resolvePredTarget(resolvePredTarget), .mispredict(s_mispredict), .redirectPC(s_redirectPC),
        .branchCount(s_branchCount), .mispredictCount(s_mispredictCount)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic res(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
        resolveValid = 1'b1; resolvePC = pc; resolveTaken = t; resolveTarget = tgt;
        resolvePredTaken = pt; resolvePredTarget = ptgt;
        #1;
    endtask

    task automatic idle();
        resolveValid = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        fetchPC = pc;
        #1;
        chk({tag, "_taken"}, 32'(predTaken), 32'(t));
        chk({tag, "_target"}, predTarget, tgt);
    endtask

    task automatic counts(input string tag, input logic [15:0] b, input logic [15:0] m);
        chk({tag, "_branches"}, 32'(branchCount), 32'(b));
        chk({tag, "_mispredicts"}, 32'(mispredictCount), 32'(m));
    endtask

    initial begin
        rst = 1'b1;
        fetchPC = 32'h100;
        res(32'h100, 1'b1, 32'h900, 1'b0, 32'h104);
        tick();
        tick();
        rst = 1'b0;
        idle();
        look("reset", 32'h100, 1'b0, 32'h104);
        counts("reset", 16'd0, 16'd0);

        res(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        chk("alloc_mispredict", 32'(mispredict), 32'd1);
        chk("alloc_redirect", redirectPC, 32'h200);
        tick();
        idle();
        counts("alloc", 16'd1, 16'd1);
        look("alloc", 32'h100, 1'b1, 32'h200);

        res(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        chk("hit_ok_mispredict", 32'(mispredict), 32'd0);
        repeat (3) tick();
        res(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        chk("nt_mispredict", 32'(mispredict), 32'd1);
        chk("nt_redirect", redirectPC, 32'h104);
        tick();
        idle();
        look("sat_nt1", 32'h100, 1'b1, 32'h200);
        res(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        tick();
        idle();
        look("sat_nt2", 32'h100, 1'b0, 32'h104);
        res(32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        chk("nt_ok_mispredict", 32'(mispredict), 32'd0);
        repeat (2) tick();
        res(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        tick();
        idle();
        look("floor_hold", 32'h100, 1'b0, 32'h104);
        res(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        tick();
        idle();
        look("floor_climb", 32'h100, 1'b1, 32'h200);
        counts("sat", 16'd10, 16'd5);

        res(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        chk("tgt_mispredict", 32'(mispredict), 32'd1);
        chk("tgt_redirect", redirectPC, 32'h300);
        tick();
        idle();
        look("tgt_new", 32'h100, 1'b1, 32'h300);

        res(32'h140, 1'b0, 32'h400, 1'b0, 32'h144);
        chk("alias_nt_mispredict", 32'(mispredict), 32'd0);
        chk("alias_nt_redirect", redirectPC, 32'h144);
        tick();
        idle();
        look("alias_kept", 32'h100, 1'b1, 32'h300);
        look("alias_miss", 32'h140, 1'b0, 32'h144);
        res(32'h140, 1'b1, 32'h400, 1'b0, 32'h144);
        tick();
        idle();
        look("alias_evicted", 32'h100, 1'b0, 32'h104);
        look("alias_alloc", 32'h140, 1'b1, 32'h400);
        counts("alias", 16'd13, 16'd7);

        fetchPC = 32'h140;
        res(32'h140, 1'b0, 32'h400, 1'b1, 32'h400);
        chk("same_cycle_old", 32'(predTaken), 32'd1);
        tick();
        chk("same_cycle_new", 32'(predTaken), 32'd0);
        idle();

        resolvePC = 32'hFFFF_FFFC;
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        chk("idle_mispredict", 32'(mispredict), 32'd0);
        chk("idle_redirect", redirectPC, 32'h0000_0000);

        rst = 1'b1;
        res(32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
        tick();
        rst = 1'b0;
        idle();
        counts("rst_resolve", 16'd0, 16'd0);
        look("rst_resolve", 32'h140, 1'b0, 32'h144);

        res(32'h180, 1'b0, 32'h0, 1'b1, 32'h700);
        repeat (15) tick();
        chk("stat4_at15_branches", 32'(s_branchCount), 32'hF);
        chk("stat4_at15_mispredicts", 32'(s_mispredictCount), 32'hF);
        repeat (5) tick();
        idle();
        chk("stat4_hold_branches", 32'(s_branchCount), 32'hF);
        chk("stat4_hold_mispredicts", 32'(s_mispredictCount), 32'hF);
        counts("stat16", 16'd20, 16'd20);
        look("nt_miss_no_alloc", 32'h180, 1'b0, 32'h184);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor for the 3-stage RISC-V core. It is the predicting end of the branch resolution path; the execute-stage branch comparator is the resolving end.
- A direct-mapped table holds a branch target buffer (BTB) and 2-bit saturating counters. It supplies a predicted next PC at fetch.
- It is trained by resolved outcomes from execute, and it raises the mispredict/redirect signal that the pipeline uses to flush.

Parameters:
- ENTRIES, 16, number of table entries; must be a power of 2, minimum 2.
- INDEX_BITS, $clog2(ENTRIES), index width; derived, do not override.
- STAT_BITS, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  core clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- fetchPC  input  32  PC of the instruction being fetched.
- predTaken  output  1  prediction for fetchPC: taken.
- predTarget  output  32  predicted next PC.
- resolveValid  input  1  execute stage holds a resolved branch or jump this cycle.
- resolvePC  input  32  PC of the resolved instruction.
- resolveTaken  input  1  actual outcome (the comparator's branchTaken).
- resolveTarget  input  32  computed taken target.
- resolvePredTaken  input  1  predTaken carried down the pipe with the instruction.
- resolvePredTarget  input  32  predTarget carried down the pipe.
- mispredict  output  1  flush fetch/decode and redirect this cycle.
- redirectPC  output  32  correct next PC when mispredict=1.
- branchCount  output  STAT_BITS  resolved branches since reset; saturating.
- mispredictCount  output  STAT_BITS  mispredicts since reset; saturating.

Behaviour:
- Address split:
  - index = PC[INDEX_BITS+1:2].
  - tag = PC[31:INDEX_BITS+2].
  - PC[1:0] is ignored.
- Entry contents: valid (1), tag, target (32), ctr (2).
- Reset (rst=1 at a rising edge):
  - all valid=0, all ctr=2'b01, all targets=0.
  - branchCount=0, mispredictCount=0.
  - Reset takes priority over a same-cycle update.
  - A resolve presented during reset is discarded.
- Lookup (combinational from the registered table):
  - hit = valid[index] & (tag[index]==tag(fetchPC)).
  - predTaken = hit & ctr[index][1].
  - predTarget = predTaken ? target[index] : fetchPC+32'd4, with 32-bit wrap.
  - During and after reset: predTaken=0 and predTarget=fetchPC+4.
- Mispredict and redirect (combinational, same cycle as resolveValid):
  - mispredict = resolveValid & ((resolvePredTaken != resolveTaken) | (resolveTaken & (resolvePredTarget != resolveTarget))).
  - redirectPC = resolveTaken ? resolveTarget : resolvePC+32'd4.
  - When resolveValid=0: mispredict=0 and redirectPC=resolvePC+4.
- Update (rising edge, resolveValid=1, rst=0), with r = index(resolvePC):
  - Hit, taken: ctr increments, saturating at 2'b11; target=resolveTarget.
  - Hit, not taken: ctr decrements, saturating at 2'b00; target unchanged.
  - Miss, taken: allocate the entry (replace whatever is there): valid=1, tag=tag(resolvePC), target=resolveTarget, ctr=2'b10.
  - Miss, not taken: table unchanged; no allocation.
- Statistics (rising edge):
  - branchCount increments when resolveValid=1.
  - mispredictCount increments when mispredict=1.
  - Both hold at all-ones and do not wrap.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents; there is no bypass. The new value is visible from the next cycle.
- Aliasing: different PCs with the same index and a different tag evict each other only on a taken allocate.
- No stall input. The pipeline guarantees resolveValid is asserted once per resolved instruction.

Test Plan:
- Reset, then fetchPC=0x100 -> predTaken=0, predTarget=0x104, counters 0.
- Resolve PC=0x100, taken, target 0x200, predTaken=0 -> mispredict=1, redirectPC=0x200, mispredictCount=1. Next cycle fetchPC=0x100 -> predTaken=1, predTarget=0x200.
- Counter saturation at 0x100:
  - Resolve taken twice more: ctr reaches 11; a third taken leaves it at 11.
  - Then resolve not-taken 2 times: predTaken=1 after the first, 0 after the second.
  - Further not-taken: ctr holds at 00.
- Target change: entry 0x100 -> 0x200 is hit; resolve taken with resolvePredTarget=0x200, resolveTarget=0x300 -> mispredict=1, redirectPC=0x300; next lookup predTarget=0x300.
- Aliasing and miss handling (ENTRIES=16):
  - Allocate 0x100, then resolve 0x140 (same index) not-taken -> 0x100 entry kept.
  - Then resolve 0x140 taken -> fetch 0x100 gives predTaken=0, fetch 0x140 gives predTaken=1.
- Boundaries:
  - Same-cycle fetch and update of the same index -> old value returned.
  - rst asserted during resolveValid -> table cleared, counters 0.
  - fetchPC=0xFFFFFFFC -> predTarget=0x00000000.
  - Force STAT_BITS=4 and drive 20 mispredicts -> both counters hold at 0xF.
